// File: rtl/fpu_op_sequencer_pkg.sv
// Shared definitions for the FPU op sequencer: opcodes, FSM states, float field widths, flag bits.
package fpu_op_sequencer_pkg;

  localparam int FP_S = 1;
  localparam int FP_E = 7;
  localparam int FP_M = 15;
  localparam int FP_W = FP_S + FP_E + FP_M;

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_SUB  = 3'd1;
  localparam logic [2:0] OP_MUL  = 3'd2;
  localparam logic [2:0] OP_DIV  = 3'd3;
  localparam logic [2:0] OP_SQRT = 3'd4;
  localparam logic [2:0] OP_MOV  = 3'd5;
  localparam logic [2:0] OP_SYNC = 3'd6;
  localparam logic [2:0] OP_ILL  = 3'd7;

  localparam int FLAG_ZERO = 0;
  localparam int FLAG_OVF  = 1;
  localparam int FLAG_UNF  = 2;
  localparam int FLAG_W    = 3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_SETTLE,
    ST_WAIT,
    ST_WB,
    ST_DRAIN
  } state_e;

  typedef struct packed {
    logic [2:0] op;
    logic [1:0] dst;
    logic [1:0] srca;
    logic [1:0] srcb;
  } cmd_t;

  localparam int CMD_W = $bits(cmd_t);

endpackage

// File: rtl/fpu_seq_fifo.sv
// Synchronous command FIFO; output is the head entry, pop takes effect at the clock edge.
// Push is refused when full unless a pop happens in the same cycle (level then unchanged).
module fpu_seq_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 9
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (level == (AW+1)'(DEPTH));
  assign empty   = (level == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointers are AW bits wide, so DEPTH being a power of two makes wrap free.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/fpu_op_sequencer.sv
// Queues FPU commands and runs them one at a time against a 4-entry register file; done is registered.
// FPU_SEQ_TIMEOUT_EN adds a WAIT/DRAIN watchdog with a sticky err_timeout output.
module fpu_op_sequencer
  import fpu_op_sequencer_pkg::*;
#(
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [2:0]        cmd_op,
  input  logic [1:0]        cmd_dst,
  input  logic [1:0]        cmd_srca,
  input  logic [1:0]        cmd_srcb,
  input  logic              host_wr_en,
  input  logic [1:0]        host_addr,
  input  logic [FP_W-1:0]   host_wdata,
  output logic [FP_W-1:0]   host_rdata,
  input  logic              flags_clr,
  output logic [FLAG_W-1:0] sticky_flags,
  output logic              err_illegal,
`ifdef FPU_SEQ_TIMEOUT_EN
  output logic              err_timeout,
`endif
  output logic              busy,
  output logic              done,
  output logic              fpu_add,
  output logic              fpu_sub,
  output logic              fpu_mul,
  output logic              fpu_div,
  output logic              fpu_sqrt,
  output logic [FP_W-1:0]   fpu_a,
  output logic [FP_W-1:0]   fpu_b,
  input  logic [FP_W-1:0]   fpu_res,
  input  logic [FLAG_W-1:0] fpu_flags,
  input  logic              fpu_idle
);

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
    $error("fpu_op_sequencer: FIFO_DEPTH must be a power of two >= 2 and TIMEOUT_CYCLES >= 1");
  end

  state_e                      state, state_nxt;
  cmd_t                        push_cmd, head, cur;
  logic [CMD_W-1:0]            head_raw;
  logic                        fifo_full, fifo_empty, pop;
  logic [$clog2(FIFO_DEPTH):0] fifo_level;
  logic [FP_W-1:0]             regs [4];
  logic [FP_W-1:0]             a_q, b_q;
  logic                        seq_we, done_set, illegal_set, to_hit;
  logic [1:0]                  seq_waddr;
  logic [FP_W-1:0]             seq_wdata;

  assign push_cmd = '{op: cmd_op, dst: cmd_dst, srca: cmd_srca, srcb: cmd_srcb};
  assign head     = cmd_t'(head_raw);

  fpu_seq_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(CMD_W)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (cmd_valid & cmd_ready),
    .din   (push_cmd),
    .pop   (pop),
    .dout  (head_raw),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  assign cmd_ready  = ~fifo_full;
  assign busy       = (fifo_level != '0) | (state != ST_IDLE);
  assign host_rdata = regs[host_addr];
  // Operands come straight from the regfile in ISSUE, then from the captured copy until the op ends.
  assign fpu_a      = (state == ST_ISSUE) ? regs[cur.srca] : a_q;
  assign fpu_b      = (state == ST_ISSUE) ? regs[cur.srcb] : b_q;

`ifdef FPU_SEQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] wd_cnt;
  logic          to_fire;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                      wd_cnt <= '0;
    else if (state == ST_WAIT || state == ST_DRAIN) wd_cnt <= wd_cnt + 1'b1;
    else                                            wd_cnt <= '0;
  end

  assign to_hit  = (wd_cnt == TW'(TIMEOUT_CYCLES - 1));
  assign to_fire = to_hit & ~fpu_idle & (state == ST_WAIT || state == ST_DRAIN);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)          err_timeout <= 1'b0;
    else if (to_fire)   err_timeout <= 1'b1;
    else if (flags_clr) err_timeout <= 1'b0;
  end
`else
  assign to_hit = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    pop         = 1'b0;
    seq_we      = 1'b0;
    seq_waddr   = cur.dst;
    seq_wdata   = fpu_res;
    done_set    = 1'b0;
    illegal_set = 1'b0;
    fpu_add     = 1'b0;
    fpu_sub     = 1'b0;
    fpu_mul     = 1'b0;
    fpu_div     = 1'b0;
    fpu_sqrt    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop = 1'b1;
          case (head.op)
            OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_SQRT: state_nxt = ST_ISSUE;
            OP_MOV: begin
              seq_we    = 1'b1;
              seq_waddr = head.dst;
              seq_wdata = regs[head.srca];
              done_set  = 1'b1;
            end
            OP_SYNC: state_nxt = ST_DRAIN;
            default: begin
              illegal_set = 1'b1;
              done_set    = 1'b1;
            end
          endcase
        end
      end
      ST_ISSUE: begin
        fpu_add   = (cur.op == OP_ADD);
        fpu_sub   = (cur.op == OP_SUB);
        fpu_mul   = (cur.op == OP_MUL);
        fpu_div   = (cur.op == OP_DIV);
        fpu_sqrt  = (cur.op == OP_SQRT);
        state_nxt = ST_SETTLE;
      end
      // The fpu may still report idle for a cycle after the start pulse.
      ST_SETTLE: state_nxt = ST_WAIT;
      ST_WAIT: begin
        if (fpu_idle) begin
          state_nxt = ST_WB;
        end else if (to_hit) begin
          state_nxt = ST_IDLE;
          done_set  = 1'b1;
        end
      end
      ST_WB: begin
        seq_we    = 1'b1;
        done_set  = 1'b1;
        state_nxt = ST_IDLE;
      end
      ST_DRAIN: begin
        if (fpu_idle || to_hit) begin
          done_set  = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur          <= '0;
      a_q          <= '0;
      b_q          <= '0;
      done         <= 1'b0;
      sticky_flags <= '0;
      err_illegal  <= 1'b0;
      for (int i = 0; i < 4; i++) regs[i] <= '0;
    end else begin
      done <= done_set;
      if (pop) cur <= head;
      if (state == ST_ISSUE) begin
        a_q <= regs[cur.srca];
        b_q <= regs[cur.srcb];
      end
      // Sequencer writeback beats a host write to the same entry.
      for (int i = 0; i < 4; i++) begin
        if (seq_we && seq_waddr == 2'(i))         regs[i] <= seq_wdata;
        else if (host_wr_en && host_addr == 2'(i)) regs[i] <= host_wdata;
      end
      if (state == ST_WB) sticky_flags <= (flags_clr ? '0 : sticky_flags) | fpu_flags;
      else if (flags_clr) sticky_flags <= '0;
      if (illegal_set)    err_illegal <= 1'b1;
      else if (flags_clr) err_illegal <= 1'b0;
    end
  end

endmodule
